// File: rtl/mmu_reg_access_ctrl_pkg.sv
// mmu_reg_access_ctrl_pkg: shared types and constants for the MMU special-register sequencer
package mmu_reg_access_ctrl_pkg;
    localparam int NTHREADIDMSB = 1;
    typedef struct packed {
        logic clk;
    } iu_clk_type;
    typedef enum logic [2:0] {
        SEL_CTRL = 3'd0,
        SEL_CTP  = 3'd1,
        SEL_CTX  = 3'd2,
        SEL_FSR  = 3'd3,
        SEL_FAR  = 3'd4
    } mmu_reg_sel_e;
    typedef logic [23:0] mmu_control_register_ram_type;
    typedef logic [31:0] mmu_context_table_pointer_register_ram_type;
    typedef logic [7:0]  mmu_context_register_ram_type;
    typedef struct packed {
        logic [7:0] ebe;
        logic [1:0] l;
        logic [2:0] at;
        logic [2:0] ft;
        logic       fav;
        logic       ow;
    } mmu_fault_status_register_ram_type;
    typedef logic [31:0] mmu_fault_address_register_ram_type;
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RD_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP    = 2'd2;
    localparam logic [1:0] ST_F_RD    = 2'd3;
endpackage

// File: rtl/mmu_reg_access_ctrl.sv
// mmu_reg_access_ctrl: sequences IU MMU-register accesses and fault logging onto the per-thread register files
module mmu_reg_access_ctrl
    import mmu_reg_access_ctrl_pkg::*;
#(
    parameter logic [7:0] IMPL_VER   = 8'h00,
    parameter bit         CHK_PARITY = 1'b1
) (
    input  iu_clk_type                                  gclk,
    input  logic                                        rst,
    input  logic                                        req_valid,
    output logic                                        req_ready,
    input  logic                                        req_we,
    input  logic [NTHREADIDMSB:0]                       req_tid,
    input  logic [2:0]                                  req_sel,
    input  logic [31:0]                                 req_wdata,
    output logic                                        rsp_valid,
    output logic [31:0]                                 rsp_rdata,
    output logic                                        rsp_err,
    input  logic                                        flt_valid,
    output logic                                        flt_ready,
    input  logic [NTHREADIDMSB:0]                       flt_tid,
    input  mmu_fault_status_register_ram_type           flt_fsr,
    input  mmu_fault_address_register_ram_type          flt_far,
    output logic                                        ctrl_we,
    output logic [NTHREADIDMSB:0]                       ctrl_wtid,
    output mmu_control_register_ram_type                ctrl_din,
    output logic [NTHREADIDMSB:0]                       ctrl_rtid,
    input  mmu_control_register_ram_type                ctrl_dout,
    input  logic                                        ctrl_luterr,
    output logic                                        ctx_we,
    output logic [NTHREADIDMSB:0]                       ctx_wtid,
    output mmu_context_register_ram_type                ctx_din,
    output logic [NTHREADIDMSB:0]                       ctx_rtid,
    input  mmu_context_register_ram_type                ctx_dout,
    input  logic                                        ctx_luterr,
    output logic                                        ctp_we,
    output logic [NTHREADIDMSB:0]                       ctp_wtid,
    output mmu_context_table_pointer_register_ram_type  ctp_din,
    output logic [NTHREADIDMSB:0]                       ctp_rtid,
    input  mmu_context_table_pointer_register_ram_type  ctp_dout,
    input  logic                                        ctp_luterr,
    output logic                                        fsr_we,
    output logic [NTHREADIDMSB:0]                       fsr_wtid,
    output mmu_fault_status_register_ram_type           fsr_din,
    output logic [NTHREADIDMSB:0]                       fsr_rtid,
    input  mmu_fault_status_register_ram_type           fsr_dout,
    input  logic                                        fsr_luterr,
    output logic                                        far_we,
    output logic [NTHREADIDMSB:0]                       far_wtid,
    output mmu_fault_address_register_ram_type          far_din,
    output logic [NTHREADIDMSB:0]                       far_rtid,
    input  mmu_fault_address_register_ram_type          far_dout,
    input  logic                                        far_luterr
);
    logic                              w_clk;
    logic [1:0]                        r_state;
    logic [2:0]                        r_sel;
    logic [NTHREADIDMSB:0]             r_tid;
    mmu_fault_status_register_ram_type r_flt_fsr;
    mmu_fault_address_register_ram_type r_flt_far;
    mmu_fault_status_register_ram_type w_new_fsr;
    logic                              w_idle;
    logic                              w_take_flt;
    logic                              w_sel_ok;
    logic                              w_st;
    logic                              w_ld;
    logic                              w_clr;
    logic                              w_frd;
    logic [4:0]                        w_st_hit;
    logic [4:0]                        w_ld_hit;
    logic [31:0]                       w_rdata;
    logic                              w_luterr;

    assign w_clk      = gclk.clk;
    assign w_idle     = (r_state == ST_IDLE) & ~rst;
    assign flt_ready  = w_idle;
    assign req_ready  = w_idle & ~flt_valid;
    assign w_take_flt = w_idle & flt_valid;
    assign w_sel_ok   = req_sel <= SEL_FAR;
    assign w_st       = req_ready & req_valid & req_we & w_sel_ok;
    assign w_ld       = req_ready & req_valid & ~req_we & w_sel_ok;
    assign w_clr      = (r_state == ST_RD_WAIT) & (r_sel == SEL_FSR);
    assign w_frd      = r_state == ST_F_RD;
    assign rsp_valid  = r_state == ST_RESP;

    for (genvar i = 0; i < 5; i++) begin : g_hit
        assign w_st_hit[i] = w_st & (req_sel == 3'(i));
        assign w_ld_hit[i] = w_ld & (req_sel == 3'(i));
    end

    assign ctrl_we   = w_st_hit[SEL_CTRL];
    assign ctrl_wtid = ctrl_we ? req_tid : '0;
    assign ctrl_din  = ctrl_we ? req_wdata[23:0] : '0;
    assign ctrl_rtid = w_ld_hit[SEL_CTRL] ? req_tid : '0;
    assign ctp_we    = w_st_hit[SEL_CTP];
    assign ctp_wtid  = ctp_we ? req_tid : '0;
    assign ctp_din   = ctp_we ? req_wdata : '0;
    assign ctp_rtid  = w_ld_hit[SEL_CTP] ? req_tid : '0;
    assign ctx_we    = w_st_hit[SEL_CTX];
    assign ctx_wtid  = ctx_we ? req_tid : '0;
    assign ctx_din   = ctx_we ? req_wdata[7:0] : '0;
    assign ctx_rtid  = w_ld_hit[SEL_CTX] ? req_tid : '0;
    assign fsr_we    = w_st_hit[SEL_FSR] | w_clr | w_frd;
    assign fsr_wtid  = w_st_hit[SEL_FSR] ? req_tid : (w_clr | w_frd) ? r_tid : '0;
    assign fsr_din   = w_st_hit[SEL_FSR] ? mmu_fault_status_register_ram_type'(req_wdata[17:0]) :
                       w_frd ? w_new_fsr : '0;
    assign fsr_rtid  = w_take_flt ? flt_tid : w_ld_hit[SEL_FSR] ? req_tid : '0;
    assign far_we    = w_st_hit[SEL_FAR] | w_frd;
    assign far_wtid  = w_frd ? r_tid : w_st_hit[SEL_FAR] ? req_tid : '0;
    assign far_din   = w_frd ? r_flt_far : w_st_hit[SEL_FAR] ? req_wdata : '0;
    assign far_rtid  = w_ld_hit[SEL_FAR] ? req_tid : '0;

    assign w_rdata  = r_sel == SEL_CTRL ? {IMPL_VER, ctrl_dout} :
                      r_sel == SEL_CTP  ? ctp_dout :
                      r_sel == SEL_CTX  ? {24'b0, ctx_dout} :
                      r_sel == SEL_FSR  ? {14'b0, fsr_dout} : far_dout;
    assign w_luterr = r_sel == SEL_CTRL ? ctrl_luterr :
                      r_sel == SEL_CTP  ? ctp_luterr :
                      r_sel == SEL_CTX  ? ctx_luterr :
                      r_sel == SEL_FSR  ? fsr_luterr : far_luterr;

    // New fault record: an unread previous fault or an unreadable old FSR marks overwrite
    always_comb begin
        w_new_fsr    = r_flt_fsr;
        w_new_fsr.ow = (fsr_dout.ft != 3'b0) | fsr_dout.ow | fsr_luterr;
    end

    // Sequencer state, latched request/fault context and the held response
    always_ff @(posedge w_clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_sel     <= '0;
            r_tid     <= '0;
            r_flt_fsr <= '0;
            r_flt_far <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (flt_valid) begin
                        r_state   <= ST_F_RD;
                        r_tid     <= flt_tid;
                        r_flt_fsr <= flt_fsr;
                        r_flt_far <= flt_far;
                    end else if (req_valid) begin
                        r_sel <= req_sel;
                        r_tid <= req_tid;
                        if (!req_we && w_sel_ok) begin
                            r_state <= ST_RD_WAIT;
                        end else begin
                            r_state   <= ST_RESP;
                            rsp_rdata <= '0;
                            rsp_err   <= ~w_sel_ok;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    r_state   <= ST_RESP;
                    rsp_rdata <= w_rdata;
                    rsp_err   <= CHK_PARITY & w_luterr;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mmu_reg_access_ctrl.sv
// tb_mmu_reg_access_ctrl: directed self-checking bench with behavioural per-thread register files
module tb_mmu_reg_access_ctrl;
    import mmu_reg_access_ctrl_pkg::*;

    logic clk = 1'b0;
    iu_clk_type gclk;
    logic rst = 1'b1;
    logic req_valid = 1'b0, req_ready, req_we = 1'b0;
    logic [1:0] req_tid = '0;
    logic [2:0] req_sel = '0;
    logic [31:0] req_wdata = '0;
    logic rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic flt_valid = 1'b0, flt_ready;
    logic [1:0] flt_tid = '0;
    mmu_fault_status_register_ram_type flt_fsr = '0;
    mmu_fault_address_register_ram_type flt_far = '0;
    logic ctrl_we, ctx_we, ctp_we, fsr_we, far_we;
    logic [1:0] ctrl_wtid, ctx_wtid, ctp_wtid, fsr_wtid, far_wtid;
    logic [1:0] ctrl_rtid, ctx_rtid, ctp_rtid, fsr_rtid, far_rtid;
    mmu_control_register_ram_type ctrl_din, ctrl_dout;
    mmu_context_register_ram_type ctx_din, ctx_dout;
    mmu_context_table_pointer_register_ram_type ctp_din, ctp_dout;
    mmu_fault_status_register_ram_type fsr_din, fsr_dout;
    mmu_fault_address_register_ram_type far_din, far_dout;
    logic ctrl_luterr = 1'b0, ctx_luterr = 1'b0, ctp_luterr = 1'b0, fsr_luterr = 1'b0, far_luterr = 1'b0;
    logic [4:0] wes;
    logic [9:0] rtids;
    int n_chk = 0;
    int n_fail = 0;

    logic [23:0] m_ctrl [4];
    logic [7:0]  m_ctx  [4];
    logic [31:0] m_ctp  [4];
    logic [17:0] m_fsr  [4];
    logic [31:0] m_far  [4];

    assign gclk.clk = clk;
    assign wes   = {ctrl_we, ctp_we, ctx_we, fsr_we, far_we};
    assign rtids = {ctrl_rtid, ctp_rtid, ctx_rtid, fsr_rtid, far_rtid};
    always #5 clk = ~clk;

    mmu_reg_access_ctrl #(.IMPL_VER(8'hA5), .CHK_PARITY(1'b1)) dut (
        .gclk(gclk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_tid(req_tid),
        .req_sel(req_sel), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .flt_valid(flt_valid), .flt_ready(flt_ready), .flt_tid(flt_tid), .flt_fsr(flt_fsr), .flt_far(flt_far),
        .ctrl_we(ctrl_we), .ctrl_wtid(ctrl_wtid), .ctrl_din(ctrl_din), .ctrl_rtid(ctrl_rtid),
        .ctrl_dout(ctrl_dout), .ctrl_luterr(ctrl_luterr),
        .ctx_we(ctx_we), .ctx_wtid(ctx_wtid), .ctx_din(ctx_din), .ctx_rtid(ctx_rtid),
        .ctx_dout(ctx_dout), .ctx_luterr(ctx_luterr),
        .ctp_we(ctp_we), .ctp_wtid(ctp_wtid), .ctp_din(ctp_din), .ctp_rtid(ctp_rtid),
        .ctp_dout(ctp_dout), .ctp_luterr(ctp_luterr),
        .fsr_we(fsr_we), .fsr_wtid(fsr_wtid), .fsr_din(fsr_din), .fsr_rtid(fsr_rtid),
        .fsr_dout(fsr_dout), .fsr_luterr(fsr_luterr),
        .far_we(far_we), .far_wtid(far_wtid), .far_din(far_din), .far_rtid(far_rtid),
        .far_dout(far_dout), .far_luterr(far_luterr)
    );

    // Register files: synchronous write, registered read (old data on a same-edge write)
    always @(posedge clk) begin
        if (ctrl_we) m_ctrl[ctrl_wtid] <= ctrl_din;
        if (ctx_we)  m_ctx[ctx_wtid]   <= ctx_din;
        if (ctp_we)  m_ctp[ctp_wtid]   <= ctp_din;
        if (fsr_we)  m_fsr[fsr_wtid]   <= fsr_din;
        if (far_we)  m_far[far_wtid]   <= far_din;
        ctrl_dout <= m_ctrl[ctrl_rtid];
        ctx_dout  <= m_ctx[ctx_rtid];
        ctp_dout  <= m_ctp[ctp_rtid];
        fsr_dout  <= m_fsr[fsr_rtid];
        far_dout  <= m_far[far_rtid];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic store(input logic [2:0] sel, input logic [1:0] tid, input logic [31:0] wd);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_sel = sel; req_tid = tid; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic load_chk(input string tag, input logic [2:0] sel, input logic [1:0] tid,
                            input logic [31:0] exp_rd, input logic exp_err);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_sel = sel; req_tid = tid;
        #1 chk({tag, "_ready"}, 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        chk({tag, "_wait"}, 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk({tag, "_vld"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_rdata"}, rsp_rdata, exp_rd);
        chk({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
    endtask

    task automatic fault(input logic [1:0] tid, input logic [17:0] fsr, input logic [31:0] far);
        @(negedge clk);
        flt_valid = 1'b1; flt_tid = tid; flt_fsr = fsr; flt_far = far;
        #1 chk("flt_ready", 32'(flt_ready), 32'd1);
        chk("flt_rtid", 32'(fsr_rtid), 32'(tid));
        @(negedge clk);
        flt_valid = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        chk("rst_ready", {30'b0, req_ready, flt_ready}, 32'd0);
        chk("rst_rsp", {30'b0, rsp_valid, rsp_err}, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_we", 32'(wes), 32'd0);
        chk("rst_rtid", 32'(rtids), 32'd0);
        rst = 1'b0;
        #1 chk("post_rst_ready", 32'(req_ready), 32'd1);
        // store ctrl tid3, checked in the accept cycle
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_sel = 3'd0; req_tid = 2'd3; req_wdata = 32'h0000_0001;
        #1 chk("st_we", 32'(wes), 32'b10000);
        chk("st_wtid", 32'(ctrl_wtid), 32'd3);
        chk("st_din", 32'(ctrl_din), 32'h1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("st_rsp", {30'b0, rsp_valid, rsp_err}, 32'b10);
        chk("st_rdata", rsp_rdata, 32'd0);
        @(negedge clk);
        chk("st_rsp_pulse", 32'(rsp_valid), 32'd0);
        load_chk("ld_ctrl", 3'd0, 2'd3, 32'hA500_0001, 1'b0);
        @(negedge clk);
        chk("rdata_held", rsp_rdata, 32'hA500_0001);
        store(3'd3, 2'd2, 32'd0);
        store(3'd2, 2'd1, 32'h0000_005A);
        // first fault on clear FSR: ow=0
        fault(2'd2, 18'h00047, 32'h8000_1000);
        chk("f1_we", 32'(wes), 32'b00011);
        chk("f1_wtid", {28'b0, fsr_wtid, far_wtid}, 32'hA);
        chk("f1_fsr", {14'b0, fsr_din}, 32'h46);
        chk("f1_far", far_din, 32'h8000_1000);
        // second fault before a read: ow=1
        fault(2'd2, 18'h00047, 32'h8000_2000);
        chk("f2_fsr", {14'b0, fsr_din}, 32'h47);
        chk("f2_far", far_din, 32'h8000_2000);
        // FSR read returns the log, then clears it in the wait cycle
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_sel = 3'd3; req_tid = 2'd2;
        #1 chk("ld_fsr_rtid", 32'(fsr_rtid), 32'd2);
        @(negedge clk);
        req_valid = 1'b0;
        chk("clr_we", 32'(wes), 32'b00010);
        chk("clr_din", {14'b0, fsr_din}, 32'd0);
        chk("clr_wtid", 32'(fsr_wtid), 32'd2);
        @(negedge clk);
        chk("ld_fsr_vld", 32'(rsp_valid), 32'd1);
        chk("ld_fsr_rdata", rsp_rdata, 32'h47);
        load_chk("ld_fsr_again", 3'd3, 2'd2, 32'd0, 1'b0);
        // simultaneous request and fault: fault first, request 2 cycles later
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_sel = 3'd4; req_tid = 2'd2;
        flt_valid = 1'b1; flt_tid = 2'd2; flt_fsr = 18'h00008; flt_far = 32'h1234_0000;
        #1 chk("sim_flt_ready", 32'(flt_ready), 32'd1);
        chk("sim_req_ready0", 32'(req_ready), 32'd0);
        @(negedge clk);
        flt_valid = 1'b0;
        chk("sim_req_ready1", 32'(req_ready), 32'd0);
        chk("sim_fsr", {14'b0, fsr_din}, 32'h08);
        @(negedge clk);
        chk("sim_req_ready2", 32'(req_ready), 32'd1);
        chk("sim_far_rtid", 32'(far_rtid), 32'd2);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("sim_vld", 32'(rsp_valid), 32'd1);
        chk("sim_rdata", rsp_rdata, 32'h1234_0000);
        // invalid select
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_sel = 3'd6; req_tid = 2'd0;
        #1 chk("inv_we", 32'(wes), 32'd0);
        chk("inv_rtid", 32'(rtids), 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        chk("inv_rsp", {30'b0, rsp_valid, rsp_err}, 32'b11);
        chk("inv_rdata", rsp_rdata, 32'd0);
        // parity error on ctx
        ctx_luterr = 1'b1;
        load_chk("ld_ctx_par", 3'd2, 2'd1, 32'h0000_005A, 1'b1);
        ctx_luterr = 1'b0;
        // reset during RD_WAIT of an FSR read: no response, no clear
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_sel = 3'd3; req_tid = 2'd2;
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        #1 chk("rrst_we", 32'(wes), 32'd0);
        chk("rrst_vld", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("rrst_vld2", 32'(rsp_valid), 32'd0);
        rst = 1'b0;
        #1 chk("rrst_ready", 32'(req_ready), 32'd1);
        load_chk("ld_fsr_kept", 3'd3, 2'd2, 32'h08, 1'b0);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mmu_reg_access_ctrl.md
Name: mmu_reg_access_ctrl

Overview:
Per-thread initiator/sequencer for the MMU special-register LUTRAMs (control, context, context-table pointer, fault status, fault address).
- Turns ASI MMU-register loads/stores from the IU into register-file read/write port cycles.
- Implements FSR read-to-clear.
- Logs translation faults with overwrite (OW) detection.
- Sits between the IU memory stage / MMU walker and the five per-thread register files.

Parameters:
IMPL_VER, 8'h00, {IMPL,VER} returned in control-register bits [31:24].
CHK_PARITY, 1, when 1, sampled luterr makes the response an error.

Ports:
gclk  in  iu_clk_type  clock bundle; all logic on gclk.clk.
rst  in  1  asynchronous active-high reset.
req_valid  in  1  register access request.
req_ready  out  1  request accepted when valid&ready.
req_we  in  1  1=store, 0=load.
req_tid  in  NTHREADIDMSB+1  thread id.
req_sel  in  3  register index (VA[10:8]): 0 ctrl, 1 ctp, 2 ctx, 3 fsr, 4 far; 5-7 invalid.
req_wdata  in  32  store data.
rsp_valid  out  1  one-cycle response pulse.
rsp_rdata  out  32  load data (0 for stores/errors).
rsp_err  out  1  invalid sel or parity error.
flt_valid  in  1  fault report from walker/TLB.
flt_ready  out  1  fault accepted.
flt_tid  in  NTHREADIDMSB+1  faulting thread.
flt_fsr  in  mmu_fault_status_register_ram_type  new FSR fields (OW ignored).
flt_far  in  mmu_fault_address_register_ram_type  faulting address.
{ctrl,ctx,ctp,fsr,far}_we  out  1 each  register-file write enable.
{ctrl,ctx,ctp,fsr,far}_wtid  out  NTHREADIDMSB+1  write thread.
{ctrl,ctx,ctp,fsr,far}_din  out  matching *_ram_type  write data.
{ctrl,ctx,ctp,fsr,far}_rtid  out  NTHREADIDMSB+1  read thread.
{ctrl,ctx,ctp,fsr,far}_dout  in  matching *_ram_type  registered read data, valid one cycle after rtid.
{ctrl,ctx,ctp,fsr,far}_luterr  in  1  parity error on dout.

Behaviour:
- Reset (async): state=IDLE; req_ready=0, flt_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, all *_we=0, all rtid/wtid=0.
- No register contents are reset; boot software initialises them.
- FSM states:
  - IDLE: flt_valid has priority. If flt_valid, assert flt_ready, latch fault, drive fsr_rtid=flt_tid -> F_RD. Else assert req_ready; on accept, latch request.
    - Store to valid sel: drive *_we/wtid/din the same cycle -> RESP.
    - Load: drive *_rtid -> RD_WAIT.
    - Invalid sel (load or store): no register access -> RESP with err=1.
  - RD_WAIT: sample dout/luterr.
    - ctrl: rdata = {IMPL_VER, dout[23:0]}.
    - Other registers: rdata = dout, zero-extended to 32 bits.
    - sel=fsr: assert fsr_we, fsr_din=0, fsr_wtid=tid (clear-on-read) -> RESP.
  - RESP: rsp_valid=1 for exactly one cycle; rsp_err = invalid | (CHK_PARITY & luterr) -> IDLE.
  - F_RD: sample fsr_dout.
    - ow = (fsr_dout.ft != 0) | fsr_dout.ow.
    - Write fsr_din = flt_fsr with ow set; write far_din=flt_far; both *_we this cycle -> IDLE.
    - Parity error on the old FSR forces ow=1.
- Latencies:
  - Store: accept -> rsp 1 cycle later.
  - Load: accept -> rsp 2 cycles later.
  - Fault: 2 cycles, blocking requests.
- req_ready and flt_ready are asserted only in IDLE. At most one access is outstanding; no pipelining.
- Simultaneous req_valid and flt_valid: fault is taken and the request waits. The request must hold stable until accepted.
- Fault for the tid whose FSR was just cleared: the clear write happens in RD_WAIT, before the fault's F_RD, so the fault is logged with ow=0.
- All *_we are single-cycle pulses, never two to the same file in one cycle.
- rsp_rdata is held until the next response.
- Reset asserted mid-operation aborts the access, with no response and no partial write.

Decomposition:
- libmmu gains:
  - MMU register-select enum (CTRL=0..FAR=4);
  - FSR field typedef (ebe[17:10], l[9:8], at[7:5], ft[4:2], fav[1], ow[0]);
  - FSM state enum.
- libiu supplies the tid width.
- No sub-module; the register-file instances stay outside and connect at the wrapper.

Test Plan:
- Store ctrl tid=3 data 32'h0000_0001, then load ctrl tid=3 -> ctrl_we pulse with wtid=3; load rsp after 2 cycles, rdata={IMPL_VER,24'h000001}, err=0.
- Fault tid=2 ft=3'b001 far=32'h8000_1000 on a clear FSR -> fsr_din.ft=1, ow=0, far_din=32'h8000_1000.
- Second fault tid=2 before any read -> ow=1.
- Load fsr tid=2 -> rdata = logged FSR, then fsr_we with din=0 in the same RD_WAIT cycle.
- Subsequent load of fsr tid=2 -> rdata=0.
- req_valid and flt_valid asserted in the same cycle -> flt_ready first, req_ready 2 cycles later, request completes correctly.
- Load sel=6 -> no *_we, rsp_err=1, rdata=0.
- Load ctx with ctx_luterr=1 and CHK_PARITY=1 -> rsp_err=1.
- Reset asserted in RD_WAIT -> no rsp_valid, no fsr_we; state=IDLE and req_ready=1 the cycle after reset releases.
